// File: rtl/bch_syndrome_unit_pkg.sv
// rtl/bch_syndrome_unit_pkg.sv - GF(2^M) helpers, FSM states and default BCH code constants
package bch_pkg;

    localparam int BCH_M = 4;
    localparam int BCH_N = 15;
    localparam int BCH_T = 2;
    localparam logic [BCH_M:0] BCH_PRIM_POLY = 5'b10011;

    // Widest field the helpers handle; callers zero-extend operands and truncate results.
    localparam int GF_W = 16;

    typedef logic [BCH_M-1:0] gf_elem_t;
    typedef enum logic {ACCUM, OUT} syn_state_e;

    function automatic int gf_degree(input logic [GF_W:0] poly);
        int d;
        d = 0;
        for (int i = 0; i <= GF_W; i++) begin
            if (poly[i]) d = i;
        end
        return d;
    endfunction

    function automatic logic [GF_W-1:0] gf_mul_alpha_pow(input logic [GF_W-1:0] elem,
                                                          input int pow,
                                                          input logic [GF_W:0] poly);
        logic [GF_W:0] v;
        int m;
        m = gf_degree(poly);
        v = {1'b0, elem};
        for (int i = 0; i < pow; i++) begin
            v = v << 1;
            if (v[m]) v = v ^ poly;
        end
        return v[GF_W-1:0];
    endfunction

    function automatic logic [GF_W-1:0] gf_square(input logic [GF_W-1:0] elem,
                                                   input logic [GF_W:0] poly);
        logic [GF_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < GF_W; i++) begin
            if (elem[i]) acc = acc ^ gf_mul_alpha_pow(GF_W'(1), 2 * i, poly);
        end
        return acc;
    endfunction

    function automatic logic [GF_W-1:0] gf_square_n(input logic [GF_W-1:0] elem,
                                                     input int n,
                                                     input logic [GF_W:0] poly);
        logic [GF_W-1:0] v;
        v = elem;
        for (int i = 0; i < n; i++) v = gf_square(v, poly);
        return v;
    endfunction

    // j = odd_part(j) * 2^pow2_exp(j); S_j is the odd root's syndrome squared pow2_exp times.
    function automatic int odd_part(input int j);
        int o;
        o = j;
        while ((o % 2) == 0 && o > 0) o = o / 2;
        return o;
    endfunction

    function automatic int pow2_exp(input int j);
        int o;
        int k;
        o = j;
        k = 0;
        while ((o % 2) == 0 && o > 0) begin
            o = o / 2;
            k = k + 1;
        end
        return k;
    endfunction

endpackage

// File: rtl/bch_syndrome_unit_if.sv
// rtl/bch_syndrome_unit_if.sv - received-bit stream in, packed syndromes out
interface bch_syndrome_unit_if #(
    parameter int M = 4,
    parameter int T = 2
);
    logic               in_valid;
    logic               in_ready;
    logic               in_bit;
    logic               in_last;
    logic               syn_valid;
    logic               syn_ready;
    logic [2*T*M-1:0]   syn;
    logic               error_free;
    logic               len_err;

    modport master (
        output in_valid, in_bit, in_last, syn_ready,
        input  in_ready, syn_valid, syn, error_free, len_err
    );

    modport slave (
        input  in_valid, in_bit, in_last, syn_ready,
        output in_ready, syn_valid, syn, error_free, len_err
    );
endinterface

// File: rtl/bch_syndrome_unit_lfsr.sv
// rtl/bch_syndrome_unit_lfsr.sv - one Horner accumulator S_J <= S_J*alpha^J ^ r
module bch_syn_lfsr
    import bch_pkg::*;
#(
    parameter int         M         = BCH_M,
    parameter int         J         = 1,
    parameter logic [M:0] PRIM_POLY = BCH_PRIM_POLY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         in_bit,
    output logic [M-1:0] s,
    output logic [M-1:0] s_nxt
);

    logic [M-1:0] s_q;
    logic [M-1:0] s_d;

    assign s_nxt = M'(gf_mul_alpha_pow(GF_W'(s_q), J, (GF_W+1)'(PRIM_POLY))) ^ M'(in_bit);

    always_comb begin
        s_d = s_q;
        if (clr) begin
            s_d = '0;
        end else if (en) begin
            s_d = s_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign s = s_q;

endmodule

// File: rtl/bch_syndrome_unit.sv
// rtl/bch_syndrome_unit.sv - streaming BCH syndrome unit; BCH_SYN_SQUARE_EN derives even syndromes by squaring
module bch_syndrome_unit
    import bch_pkg::*;
#(
    parameter int         M         = BCH_M,
    parameter int         N         = BCH_N,
    parameter int         T         = BCH_T,
    parameter logic [M:0] PRIM_POLY = BCH_PRIM_POLY
) (
    input  logic                  clk,
    input  logic                  rst,
    bch_syndrome_unit_if.slave    bus
);

    localparam int CW = $clog2(N + 1);

`ifdef BCH_SYN_SQUARE_EN
    localparam int NACC = T;
`else
    localparam int NACC = 2 * T;
`endif

    syn_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              error_free_q, error_free_d;
    logic              len_err_q, len_err_d;
    logic              accept;
    logic              clr;
    logic              last_beat;
    logic [NACC*M-1:0] acc_s;
    logic [NACC*M-1:0] acc_nxt;
    logic [2*T*M-1:0]  syn_w;

    for (genvar i = 0; i < NACC; i++) begin : g_acc
`ifdef BCH_SYN_SQUARE_EN
        localparam int J = 2 * i + 1;
`else
        localparam int J = i + 1;
`endif
        bch_syn_lfsr #(
            .M         (M),
            .J         (J),
            .PRIM_POLY (PRIM_POLY)
        ) u_lfsr (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .en     (accept),
            .in_bit (bus.in_bit),
            .s      (acc_s[i*M +: M]),
            .s_nxt  (acc_nxt[i*M +: M])
        );
    end

`ifdef BCH_SYN_SQUARE_EN
    for (genvar j = 1; j <= 2 * T; j++) begin : g_sq
        localparam int O = odd_part(j);
        assign syn_w[j*M-1 -: M] = M'(gf_square_n(GF_W'(acc_s[((O-1)/2)*M +: M]),
                                                   pow2_exp(j), (GF_W+1)'(PRIM_POLY)));
    end
`else
    assign syn_w = acc_s;
`endif

    assign last_beat = (cnt_q == CW'(N - 1));

    // Squaring maps zero only to zero, so the odd accumulators alone decide error_free.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        error_free_d = error_free_q;
        len_err_d    = len_err_q;
        accept       = 1'b0;
        clr          = 1'b0;
        case (state_q)
            ACCUM: begin
                accept = bus.in_valid;
                if (bus.in_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (bus.in_last || last_beat) begin
                        state_d      = OUT;
                        error_free_d = ~|acc_nxt;
                        len_err_d    = bus.in_last ^ last_beat;
                    end
                end
            end
            OUT: begin
                if (bus.syn_ready) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            cnt_q        <= '0;
            error_free_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            error_free_q <= error_free_d;
            len_err_q    <= len_err_d;
        end
    end

    assign bus.in_ready   = (state_q == ACCUM);
    assign bus.syn_valid  = (state_q == OUT);
    assign bus.syn        = syn_w;
    assign bus.error_free = error_free_q;
    assign bus.len_err    = len_err_q;

endmodule
